// File: rtl/bcpu_pkg.sv
// bcpu_pkg: shared widths, thread/address types and next-PC mode for the BCPU16 core
package bcpu_pkg;
   localparam int ADDR_W   = 10;
   localparam int THREAD_W = 2;
   typedef logic [ADDR_W-1:0]   addr_t;
   typedef logic [THREAD_W-1:0] thread_id_t;
   // Next-PC selection, shared with the instruction decoder
   typedef enum logic [1:0] {NPC_INC, NPC_JUMP, NPC_HOLD} npc_mode_t;
endpackage

// File: rtl/bcpu_pc_ram.sv
// bcpu_pc_ram: per-thread PC array, one write port and two read ports
//   clk, rst          clock, synchronous active-high reset (loads START_ADDR everywhere)
//   we, waddr, wdata  write port
//   raddr_a, rdata_a  async read port (fetch slot)
//   raddr_b, rdata_b  async read port (writeback thread)
module bcpu_pc_ram import bcpu_pkg::*; #(
   parameter int                    ADDR_WIDTH  = ADDR_W,
   parameter int                    THREAD_BITS = THREAD_W,
   parameter logic [ADDR_WIDTH-1:0] START_ADDR  = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   we,
   input  logic [THREAD_BITS-1:0] waddr,
   input  logic [ADDR_WIDTH-1:0]  wdata,
   input  logic [THREAD_BITS-1:0] raddr_a,
   output logic [ADDR_WIDTH-1:0]  rdata_a,
   input  logic [THREAD_BITS-1:0] raddr_b,
   output logic [ADDR_WIDTH-1:0]  rdata_b
);
   logic [ADDR_WIDTH-1:0] pc [2**THREAD_BITS];
   always_ff @(posedge clk)
      if (rst) pc <= '{default: START_ADDR};
      else if (we) pc[waddr] <= wdata;
   assign rdata_a = pc[raddr_a];
   assign rdata_b = pc[raddr_b];
endmodule

// File: rtl/bcpu_pc_unit.sv
// bcpu_pc_unit: per-thread PC store and round-robin next-PC sequencer for the barrel core
//   CLK, RESET, CE          clock, sync active-high reset, clock enable
//   THREAD_EN               per-thread run mask
//   FETCH_VALID/THREAD/PC   registered fetch slot outputs
//   WB_VALID/THREAD/JUMP/STALL/TARGET  retiring instruction's next-PC request
//   RET_ADDR                pc[WB_THREAD]+1, combinational
module bcpu_pc_unit import bcpu_pkg::*; #(
   parameter int                    ADDR_WIDTH  = ADDR_W,
   parameter int                    THREAD_BITS = THREAD_W,
   parameter logic [ADDR_WIDTH-1:0] START_ADDR  = '0
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic                      CE,
   input  logic [2**THREAD_BITS-1:0] THREAD_EN,
   output logic                      FETCH_VALID,
   output logic [THREAD_BITS-1:0]    FETCH_THREAD,
   output logic [ADDR_WIDTH-1:0]     FETCH_PC,
   input  logic                      WB_VALID,
   input  logic [THREAD_BITS-1:0]    WB_THREAD,
   input  logic                      WB_JUMP,
   input  logic                      WB_STALL,
   input  logic [ADDR_WIDTH-1:0]     WB_TARGET,
   output logic [ADDR_WIDTH-1:0]     RET_ADDR
);
   logic [THREAD_BITS-1:0] cnt;
   logic [ADDR_WIDTH-1:0]  pc_fetch, pc_wb, wb_pc, pc_eff;
   logic                   wb_hit;
   npc_mode_t              mode;
   bcpu_pc_ram #(.ADDR_WIDTH(ADDR_WIDTH), .THREAD_BITS(THREAD_BITS), .START_ADDR(START_ADDR)) u_ram (
      .clk(CLK), .rst(RESET), .we(CE && WB_VALID), .waddr(WB_THREAD), .wdata(wb_pc),
      .raddr_a(cnt), .rdata_a(pc_fetch), .raddr_b(WB_THREAD), .rdata_b(pc_wb)
   );
   // Stall outranks jump: a WAIT that is not met must re-execute even if flagged as a jump
   always_comb begin
      mode     = WB_STALL ? NPC_HOLD : WB_JUMP ? NPC_JUMP : NPC_INC;
      wb_pc    = mode == NPC_HOLD ? pc_wb : mode == NPC_JUMP ? WB_TARGET : pc_wb + ADDR_WIDTH'(1);
      wb_hit   = WB_VALID && WB_THREAD == cnt;
      pc_eff   = wb_hit ? wb_pc : pc_fetch;
      RET_ADDR = pc_wb + ADDR_WIDTH'(1);
   end
   always_ff @(posedge CLK)
      if (RESET) begin
         cnt          <= '0;
         FETCH_VALID  <= 1'b0;
         FETCH_THREAD <= '0;
         FETCH_PC     <= START_ADDR;
      end else if (CE) begin
         cnt          <= cnt + THREAD_BITS'(1);
         FETCH_THREAD <= cnt;
         FETCH_PC     <= pc_eff;
         FETCH_VALID  <= THREAD_EN[cnt];
      end
`ifndef SYNTHESIS
   // A thread with an unretired fetch must see its writeback no later than its next slot
   logic [2**THREAD_BITS-1:0] pending, pending_nxt;
   always_comb begin
      pending_nxt = pending;
      if (WB_VALID) pending_nxt[WB_THREAD] = 1'b0;
      if (THREAD_EN[cnt]) pending_nxt[cnt] = 1'b1;
   end
   always_ff @(posedge CLK)
      if (RESET) pending <= '0;
      else if (CE) pending <= pending_nxt;
   barrel_rule: assert property (@(posedge CLK) disable iff (RESET) CE && pending[cnt] |-> wb_hit);
`endif
endmodule

// File: tb/tb_bcpu_pc_unit.sv
// tb_bcpu_pc_unit: scoreboard bench for bcpu_pc_unit against a per-thread PC reference model
module tb_bcpu_pc_unit;
   logic       CLK = 0, RESET = 1, CE = 0;
   logic [3:0] THREAD_EN = 0;
   logic       FETCH_VALID;
   logic [1:0] FETCH_THREAD;
   logic [9:0] FETCH_PC;
   logic       WB_VALID = 0, WB_JUMP = 0, WB_STALL = 0;
   logic [1:0] WB_THREAD = 0;
   logic [9:0] WB_TARGET = 0;
   logic [9:0] RET_ADDR;

   bcpu_pc_unit dut (
      .CLK(CLK), .RESET(RESET), .CE(CE), .THREAD_EN(THREAD_EN),
      .FETCH_VALID(FETCH_VALID), .FETCH_THREAD(FETCH_THREAD), .FETCH_PC(FETCH_PC),
      .WB_VALID(WB_VALID), .WB_THREAD(WB_THREAD), .WB_JUMP(WB_JUMP), .WB_STALL(WB_STALL),
      .WB_TARGET(WB_TARGET), .RET_ADDR(RET_ADDR)
   );

   always #5 CLK = ~CLK;

   typedef struct {bit v; int t; int pc;} exp_t;
   typedef struct {int due; int t;} ret_t;
   typedef struct {bit j; bit s; int tgt;} pol_t;

   exp_t sb[$];
   ret_t rq[$];
   pol_t pol[4][$];
   int   mpc[4];
   int   mcnt, edges, delay, pol_mode;
   int   cur_t, cur_pc;
   bit   cur_v;
   int   checks = 0, errors = 0;

   // Model: apply the retiring instruction's rule first, then the slot reads the (possibly new) pc
   task automatic step(input bit ce, input bit [3:0] en, input bit rst);
      pol_t p;
      bit   wv;
      int   wt, exp_ret;
      @(negedge CLK);
      RESET = rst; CE = ce; THREAD_EN = en;
      wv = 0; wt = 0; p = '{0, 0, 0};
      if (!rst && ce && rq.size() > 0 && rq[0].due == edges) begin
         wv = 1; wt = rq[0].t; void'(rq.pop_front());
         if (pol[wt].size() > 0) p = pol[wt].pop_front();
         else if (pol_mode == 1) p = '{0, 1, 0};
         else if (pol_mode == 2) p = '{($urandom % 3) == 0, ($urandom % 5) == 0, int'($urandom % 1024)};
         WB_VALID = 1; WB_THREAD = 2'(wt); WB_JUMP = p.j; WB_STALL = p.s; WB_TARGET = 10'(p.tgt);
      end else begin
         WB_VALID  = (!ce || rst) ? 1'($urandom) : 1'b0;
         WB_THREAD = 2'($urandom); WB_JUMP = 1'($urandom); WB_STALL = 1'($urandom);
         WB_TARGET = 10'($urandom);
      end
      #1;
      exp_ret = (mpc[WB_THREAD] + 1) % 1024;
      checks++;
      if (RET_ADDR !== 10'(exp_ret)) begin
         errors++;
         $display("FAIL ret_addr t=%0d got %0h want %0h", WB_THREAD, RET_ADDR, exp_ret);
      end
      if (rst) begin
         mpc = '{0, 0, 0, 0}; mcnt = 0; edges = 0;
         cur_v = 0; cur_t = 0; cur_pc = 0;
         rq.delete();
         for (int i = 0; i < 4; i++) pol[i].delete();
      end else if (ce) begin
         if (wv) mpc[wt] = p.s ? mpc[wt] : p.j ? p.tgt : (mpc[wt] + 1) % 1024;
         cur_t = mcnt; cur_pc = mpc[mcnt]; cur_v = en[mcnt];
         if (cur_v) rq.push_back('{edges + delay, mcnt});
         mcnt = (mcnt + 1) % 4;
         edges++;
      end
      sb.push_back('{cur_v, cur_t, cur_pc});
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks += 3;
            if (FETCH_VALID !== e.v) begin
               errors++;
               $display("FAIL fetch_valid got %0b want %0b", FETCH_VALID, e.v);
            end
            if (FETCH_THREAD !== 2'(e.t)) begin
               errors++;
               $display("FAIL fetch_thread got %0d want %0d", FETCH_THREAD, e.t);
            end
            if (FETCH_PC !== 10'(e.pc)) begin
               errors++;
               $display("FAIL fetch_pc t=%0d got %0h want %0h", e.t, FETCH_PC, e.pc);
            end
         end
      end
   end

   initial begin : stim
      bit [3:0] en;
      delay = 2; pol_mode = 1;
      step(0, 4'hF, 1);
      for (int i = 0; i < 8; i++) step(1, 4'hF, 0);
      pol_mode = 0;
      for (int i = 0; i < 16; i++) step(1, 4'hF, 0);
      pol[1].push_back('{1, 0, 'h3FF});
      for (int i = 0; i < 12; i++) step(1, 4'hF, 0);
      step(1, 4'hF, 1);
      delay = 4;
      pol[2].push_back('{1, 0, 'h155});
      for (int i = 0; i < 12; i++) step(1, 4'hF, 0);
      step(1, 4'hF, 1);
      delay = 2;
      pol[3].push_back('{1, 0, 'h020});
      for (int i = 0; i < 3; i++) pol[3].push_back('{1, 1, int'($urandom % 1024)});
      for (int i = 0; i < 24; i++) step(1, 4'hF, 0);
      for (int i = 0; i < 12; i++) step(1, 4'b1011, 0);
      step(0, 4'b1011, 1);
      for (int i = 0; i < 3; i++) step(0, 4'hF, 0);
      for (int d = 1; d <= 4; d++) begin
         step(1, 4'hF, 1);
         delay = d; pol_mode = 2; en = 4'hF;
         for (int i = 0; i < 300; i++) begin
            if ($urandom % 16 == 0) en = 4'($urandom);
            step(($urandom % 5) != 0, en, 0);
         end
      end
      repeat (3) @(negedge CLK);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
